// File: rtl/led_seq_pkg.sv
// led_seq_pkg -- shared types and constants for the LED sequencer.
//   state_t        : sequencer states (IDLE / RUN / PAUSE)
//   PAT_STEPn      : LED pattern shown at step n (bit 3 = leftmost LED)
//   SW_*           : speed-select codes on sw
//   step_pattern() : step index -> LED pattern
//   period_shift() : speed code -> extra bits added to DIV_BASE
package led_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    localparam logic [3:0] PAT_STEP0 = 4'b0000;
    localparam logic [3:0] PAT_STEP1 = 4'b0011;
    localparam logic [3:0] PAT_STEP2 = 4'b1001;
    localparam logic [3:0] PAT_STEP3 = 4'b0110;

    localparam logic [1:0] SW_SLOW     = 2'b00;
    localparam logic [1:0] SW_MEDIUM   = 2'b10;
    localparam logic [1:0] SW_FAST     = 2'b01;
    localparam logic [1:0] SW_FAST_ALT = 2'b11;

    function automatic logic [3:0] step_pattern(input logic [1:0] s);
        logic [3:0] p;
        case (s)
            2'd0:    p = PAT_STEP0;
            2'd1:    p = PAT_STEP1;
            2'd2:    p = PAT_STEP2;
            default: p = PAT_STEP3;
        endcase
        return p;
    endfunction

    // Period is 2^(DIV_BASE + shift) clock cycles.
    function automatic logic [1:0] period_shift(input logic [1:0] sel);
        logic [1:0] sh;
        case (sel)
            SW_SLOW:   sh = 2'd2;
            SW_MEDIUM: sh = 2'd1;
            default:   sh = 2'd0;   // SW_FAST, SW_FAST_ALT
        endcase
        return sh;
    endfunction

endpackage

// File: rtl/led_seq_ctrl_tick_gen.sv
// led_tick_gen -- prescaler producing a one-cycle step tick.
//   clk, rst  : system clock, asynchronous active-low reset
//   enable    : count only while high
//   clear     : synchronously return the count to zero (wins over counting)
//   sel       : registered speed code selecting the period
//   tick      : high for the single cycle in which the count sits at P-1
// Requires DIV_BASE >= 1.
module led_tick_gen
    import led_seq_pkg::*;
#(
    parameter int unsigned DIV_BASE = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       clear,
    input  logic [1:0] sel,
    output logic       tick
);

    localparam int unsigned CW = DIV_BASE + 2;

    logic [CW-1:0] count;
    logic [CW-1:0] last;

    // Terminal count P-1 as an all-ones field of DIV_BASE+shift bits.
    always_comb begin
        last = '0;
        case (period_shift(sel))
            2'd2:    last = '1;
            2'd1:    last = {1'b0, {(CW-1){1'b1}}};
            default: last = {2'b00, {(CW-2){1'b1}}};
        endcase
    end

    assign tick = enable && (count == last);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear || tick) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/led_seq_ctrl.sv
// led_seq_ctrl -- four-step LED pattern sequencer with start/pause/stop keys.
//   clk        : system clock (all state on rising edge)
//   rst        : asynchronous active-low reset
//   key_start  : start/resume request (debounced level, rising edge acts)
//   key_stop   : pause/stop request (debounced level, rising edge acts)
//   sw[1:0]    : speed select (00 slowest, 10 medium, 01/11 fastest)
//   dir        : 1 = count down; only used when LED_SEQ_REVERSE_EN is defined
//   led[3:0]   : current pattern, led[3] leftmost
//   step[1:0]  : current pattern index
//   running    : high only in RUN
// Build option: define LED_SEQ_REVERSE_EN to let dir reverse the stepping.
module led_seq_ctrl
    import led_seq_pkg::*;
#(
    parameter int unsigned DIV_BASE = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_start,
    input  logic       key_stop,
    input  logic [1:0] sw,
    input  logic       dir,
    output logic [3:0] led,
    output logic [1:0] step,
    output logic       running
);

    state_t     state;
    state_t     state_next;
    logic       start_q;
    logic       stop_q;
    logic       start_edge;
    logic       stop_edge;
    logic [1:0] sw_q;
    logic       sw_change;
    logic       tick;
    logic       step_clear;

    // Edge-detect registers reset high so a key held through reset is not an edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            start_q <= 1'b1;
            stop_q  <= 1'b1;
        end else begin
            start_q <= key_start;
            stop_q  <= key_stop;
        end
    end

    assign start_edge = key_start & ~start_q;
    assign stop_edge  = key_stop  & ~stop_q;

    // The prescaler is cleared on the same edge that loads the new code, so the
    // first cycle using the new period starts from zero.
    assign sw_change = (sw != sw_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sw_q <= 2'b00;
        end else begin
            sw_q <= sw;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        step_clear = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_edge && !stop_edge) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (stop_edge) begin
                    state_next = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (stop_edge) begin
                    state_next = ST_IDLE;
                    step_clear = 1'b1;
                end else if (start_edge) begin
                    state_next = ST_RUN;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Holding the prescaler at zero throughout IDLE makes the first tick land
    // exactly P cycles after the start edge.
    led_tick_gen #(
        .DIV_BASE (DIV_BASE)
    ) u_tick_gen (
        .clk    (clk),
        .rst    (rst),
        .enable (state == ST_RUN),
        .clear  ((state == ST_IDLE) || sw_change),
        .sel    (sw_q),
        .tick   (tick)
    );

`ifdef LED_SEQ_REVERSE_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            step <= 2'd0;
        end else if (step_clear) begin
            step <= 2'd0;
        end else if (tick) begin
            step <= dir ? step - 2'd1 : step + 2'd1;
        end
    end
`else
    // dir has no effect in this build.
    logic unused_dir;
    assign unused_dir = dir;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            step <= 2'd0;
        end else if (step_clear) begin
            step <= 2'd0;
        end else if (tick) begin
            step <= step + 2'd1;
        end
    end
`endif

    assign led     = step_pattern(step);
    assign running = (state == ST_RUN);

endmodule

// File: doc/led_seq_ctrl.md
LED_SEQ_CTRL -- requirements
Module: led_seq_ctrl

Interface
REQ-001 SHALL have parameter DIV_BASE, default 24: log2 of the very-fast step period in clk cycles.
REQ-002 SHALL have port clk  input  1: single system clock; all state on its rising edge.
REQ-003 SHALL have port rst  input  1: reset, asynchronous, active-low.
REQ-004 SHALL have port key_start  input  1: start/resume request, active-high level, already debounced.
REQ-005 SHALL have port key_stop  input  1: pause/stop request, active-high level, already debounced.
REQ-006 SHALL have port sw  input  2: speed select.
REQ-007 SHALL have port dir  input  1: direction, 1 = down (meaningful only per REQ-024).
REQ-008 SHALL have port led  output  4: pattern, led[3] = leftmost LED.
REQ-009 SHALL have port step  output  2: current pattern index.
REQ-010 SHALL have port running  output  1: high only in RUN.

Function
REQ-011 SHALL run on clk only; no derived clocks; stepping uses a one-cycle tick enable.
REQ-012 SHALL set step period P: sw=00 -> 2^(DIV_BASE+2) cycles; sw=10 -> 2^(DIV_BASE+1); sw=01 or 11 -> 2^DIV_BASE.
REQ-013 SHALL detect rising edges of key_start/key_stop against a one-cycle-delayed copy; only edges act.
REQ-014 SHALL implement FSM IDLE, RUN, PAUSE.
- IDLE + start edge -> RUN, prescaler cleared.
- RUN + stop edge -> PAUSE, prescaler held.
- PAUSE + start edge -> RUN, prescaler resumes from held value.
- PAUSE + stop edge -> IDLE, step cleared to 0.
- Start edge in RUN is ignored.
REQ-015 SHALL give stop priority when start and stop edges arrive in the same cycle.
REQ-016 SHALL count the prescaler only in RUN; tick fires when it reaches P-1, then it wraps to 0.
REQ-017 SHALL advance step by +1 modulo 4 on each tick: 3 -> 0 wrap.
REQ-018 SHALL map step to led combinationally from the registered step: 0 -> 0000, 1 -> 0011, 2 -> 1001, 3 -> 0110.
REQ-019 SHALL clear the prescaler on the cycle after any change of the registered sw, so the first tick after a change comes a full new P later.
REQ-020 SHALL make the first tick after IDLE->RUN occur exactly P cycles after the start edge cycle.
REQ-021 SHALL hold step and led unchanged in PAUSE.

Reset
REQ-022 SHALL on rst low, immediately and at any state: state IDLE, step 0, led 0000, running 0, prescaler 0, sw register 00.
REQ-023 SHALL reset the key edge-detect registers to 1, so a key held through reset release produces no edge.

Configuration
REQ-024 SHALL honour macro LED_SEQ_REVERSE_EN:
- Defined: dir=1 makes each tick decrement step modulo 4 (0 -> 3 wrap); dir is sampled at the tick.
- Undefined: dir is ignored and step only increments.
- The port list is identical in both cases.

Structure
REQ-025 SHALL take from shared package led_seq_pkg: state enum (IDLE/RUN/PAUSE), the four pattern constants, and the sw speed codes.
REQ-026 SHALL place prescaler and tick generation in sub-module led_tick_gen (inputs: enable, clear, period select; output: tick).

Verification (DIV_BASE=2: P = 16, 8, 4)
REQ-027 SHALL check reset: assert rst low mid-RUN at step 2 -> same-cycle-async led 0000, step 0, running 0; release -> remains IDLE with no key activity.
REQ-028 SHALL check stepping: sw=00, start edge at cycle T -> step 1 at T+16, 2 at T+32, 3 at T+48, 0 at T+64; led follows 0011, 1001, 0110, 0000.
REQ-029 SHALL check speed change: RUN with sw=10, switch to sw=01 mid-period -> next step change 4 cycles after the sw register update; thereafter every 4 cycles.
REQ-030 SHALL check pause/resume: stop edge 3 cycles into a period at step 1 -> step held for 20 idle cycles; start edge -> step 2 after remaining 5 cycles (sw=10).
REQ-031 SHALL check priority/stop: simultaneous start and stop edges in RUN -> PAUSE; second stop -> IDLE, step 0, led 0000; key_start held high through reset release -> stays IDLE.
REQ-032 SHALL check wrap-down (LED_SEQ_REVERSE_EN defined): dir=1, RUN from step 0, sw=01 -> step 3, 2, 1, 0 at 4-cycle intervals; same bench without the macro -> step 1, 2, 3, 0.
